// File: rtl/uop_sequencer_pkg.sv
// Shared micro-op definitions: word layout, opcode constants and sequencer state encoding.
// Used by the decoder and by the micro-op sequencer.
package uop_sequencer_pkg;

  localparam int UOP_W      = 32;
  localparam int REG_W      = 7;
  localparam int STEP_W     = 2;
  localparam int UOP_LAST   = 23;
  localparam int UOP_SELIMM = 22;
  localparam int UOP_UIMM_W = 16;

  localparam logic [7:0] UOP_NOP = 8'h00;
  localparam logic [7:0] UOP_LD  = 8'h0C;
  localparam logic [7:0] UOP_ST  = 8'h0D;
  localparam logic [7:0] UOP_ALU = 8'h10;
  localparam logic [7:0] UOP_BR  = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEQ,
    ST_DRAIN
  } seq_state_e;

  function automatic logic [UOP_W-1:0] uimm_sext(input logic [UOP_UIMM_W-1:0] uimm);
    return {{(UOP_W-UOP_UIMM_W){uimm[UOP_UIMM_W-1]}}, uimm};
  endfunction

endpackage

// File: rtl/uop_sequencer_rom.sv
// Microcode ROM: one-cycle synchronous read of the addressed word.
// Latency 1 cycle from rd_en/rd_addr to rd_data.
// Backpressure: the output word holds while rd_en is low; the array is loaded by the environment.
module uop_rom #(
  parameter int    ADDR_W   = 12,
  parameter int    DATA_W   = 32,
  parameter string ROM_FILE = "uoppgm.txt"
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_data_d, rd_data_q;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/uop_sequencer.sv
// Issues one micro-op per cycle to execute: direct ops pass through one register stage,
// microcoded ops walk the ROM until a LAST word, watchdog overrun or fetch of address 0.
module uop_sequencer
  import uop_sequencer_pkg::*;
#(
  parameter int    UPC_W    = 12,
  parameter int    MAX_LEN  = 16,
  parameter string ROM_FILE = "uoppgm.txt"
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [REG_W-1:0]  id_reg_d,
  input  logic [REG_W-1:0]  id_reg_s,
  input  logic [REG_W-1:0]  id_reg_t,
  input  logic [UOP_W-1:0]  id_imm,
  input  logic [STEP_W-1:0] id_step_pc,
  input  logic [UPC_W-1:0]  id_uop_pc,
  input  logic [UOP_W-1:0]  id_uop_word,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [UOP_W-1:0]  ex_uop,
  output logic [REG_W-1:0]  ex_reg_d,
  output logic [REG_W-1:0]  ex_reg_s,
  output logic [REG_W-1:0]  ex_reg_t,
  output logic [UOP_W-1:0]  ex_imm,
  output logic [STEP_W-1:0] ex_step_pc,
  output logic              ex_last,
  output logic              ex_fault
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);

  seq_state_e        state_q, state_d;
  logic [UPC_W-1:0]  upc_q, upc_d, raddr_q, raddr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REG_W-1:0]  lat_rd_q, lat_rd_d, lat_rs_q, lat_rs_d, lat_rt_q, lat_rt_d;
  logic [UOP_W-1:0]  lat_imm_q, lat_imm_d;
  logic [STEP_W-1:0] lat_step_q, lat_step_d;

  logic              ex_valid_q, ex_valid_d, ex_last_q, ex_last_d, ex_fault_q, ex_fault_d;
  logic [UOP_W-1:0]  ex_uop_q, ex_uop_d, ex_imm_q, ex_imm_d;
  logic [REG_W-1:0]  ex_rd_q, ex_rd_d, ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
  logic [STEP_W-1:0] ex_step_q, ex_step_d;

  logic              rom_en;
  logic [UPC_W-1:0]  rom_addr;
  logic [UOP_W-1:0]  rom_data;
  logic              slot_free, accept, w_last, w_fault, w_term;

  uop_rom #(.ADDR_W(UPC_W), .DATA_W(UOP_W), .ROM_FILE(ROM_FILE)) u_rom (
    .clk     (clk),
    .rd_en   (rom_en),
    .rd_addr (rom_addr),
    .rd_data (rom_data)
  );

  assign slot_free = !ex_valid_q || ex_ready;
  assign id_ready  = reset_n && (state_q == ST_IDLE) && slot_free && !flush;
  assign accept    = id_valid && id_ready;

  // raddr_q is the address whose word currently sits on the ROM output
  assign w_last  = rom_data[UOP_LAST];
  assign w_fault = (raddr_q == '0) || (!w_last && (cnt_q == CNT_W'(MAX_LEN)));
  assign w_term  = w_last || w_fault;

  always_comb begin
    state_d    = state_q;
    upc_d      = upc_q;
    raddr_d    = raddr_q;
    cnt_d      = cnt_q;
    lat_rd_d   = lat_rd_q;
    lat_rs_d   = lat_rs_q;
    lat_rt_d   = lat_rt_q;
    lat_imm_d  = lat_imm_q;
    lat_step_d = lat_step_q;
    ex_valid_d = ex_valid_q && !ex_ready;
    ex_uop_d   = ex_uop_q;
    ex_rd_d    = ex_rd_q;
    ex_rs_d    = ex_rs_q;
    ex_rt_d    = ex_rt_q;
    ex_imm_d   = ex_imm_q;
    ex_step_d  = ex_step_q;
    ex_last_d  = ex_last_q;
    ex_fault_d = ex_fault_q;
    rom_en     = 1'b0;
    rom_addr   = upc_q;

    case (state_q)
      ST_IDLE: begin
        if (accept && (id_uop_pc == '0)) begin
          ex_valid_d = 1'b1;
          ex_uop_d   = id_uop_word;
          ex_rd_d    = id_reg_d;
          ex_rs_d    = id_reg_s;
          ex_rt_d    = id_reg_t;
          ex_imm_d   = id_imm;
          ex_step_d  = id_step_pc;
          ex_last_d  = 1'b1;
          ex_fault_d = 1'b0;
        end else if (accept) begin
          lat_rd_d   = id_reg_d;
          lat_rs_d   = id_reg_s;
          lat_rt_d   = id_reg_t;
          lat_imm_d  = id_imm;
          lat_step_d = id_step_pc;
          rom_en     = 1'b1;
          rom_addr   = id_uop_pc;
          raddr_d    = id_uop_pc;
          upc_d      = id_uop_pc + UPC_W'(1);
          cnt_d      = CNT_W'(1);
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH, ST_SEQ: begin
        if (slot_free) begin
          ex_valid_d = 1'b1;
          ex_uop_d   = rom_data;
          ex_rd_d    = lat_rd_q;
          ex_rs_d    = lat_rs_q;
          ex_rt_d    = lat_rt_q;
          ex_imm_d   = rom_data[UOP_SELIMM] ? uimm_sext(rom_data[UOP_UIMM_W-1:0]) : lat_imm_q;
          ex_step_d  = (w_term && !w_fault) ? lat_step_q : '0;
          ex_last_d  = w_term;
          ex_fault_d = w_fault;
          if (w_term) begin
            state_d = ST_DRAIN;
          end else begin
            rom_en  = 1'b1;
            raddr_d = upc_q;
            upc_d   = upc_q + UPC_W'(1);
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = ST_SEQ;
          end
        end
      end
      ST_DRAIN: begin
        if (slot_free) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush drops the output slot and any word pending on the ROM output
    if (flush) begin
      state_d    = ST_IDLE;
      ex_valid_d = 1'b0;
      rom_en     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      upc_q      <= '0;
      raddr_q    <= '0;
      cnt_q      <= '0;
      lat_rd_q   <= '0;
      lat_rs_q   <= '0;
      lat_rt_q   <= '0;
      lat_imm_q  <= '0;
      lat_step_q <= '0;
      ex_valid_q <= 1'b0;
      ex_uop_q   <= {UOP_NOP, 24'h0};
      ex_rd_q    <= '0;
      ex_rs_q    <= '0;
      ex_rt_q    <= '0;
      ex_imm_q   <= '0;
      ex_step_q  <= '0;
      ex_last_q  <= 1'b0;
      ex_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      upc_q      <= upc_d;
      raddr_q    <= raddr_d;
      cnt_q      <= cnt_d;
      lat_rd_q   <= lat_rd_d;
      lat_rs_q   <= lat_rs_d;
      lat_rt_q   <= lat_rt_d;
      lat_imm_q  <= lat_imm_d;
      lat_step_q <= lat_step_d;
      ex_valid_q <= ex_valid_d;
      ex_uop_q   <= ex_uop_d;
      ex_rd_q    <= ex_rd_d;
      ex_rs_q    <= ex_rs_d;
      ex_rt_q    <= ex_rt_d;
      ex_imm_q   <= ex_imm_d;
      ex_step_q  <= ex_step_d;
      ex_last_q  <= ex_last_d;
      ex_fault_q <= ex_fault_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_uop     = ex_uop_q;
  assign ex_reg_d   = ex_rd_q;
  assign ex_reg_s   = ex_rs_q;
  assign ex_reg_t   = ex_rt_q;
  assign ex_imm     = ex_imm_q;
  assign ex_step_pc = ex_step_q;
  assign ex_last    = ex_last_q;
  assign ex_fault   = ex_fault_q;

endmodule

// File: tb/tb_uop_sequencer.sv
// Bench for uop_sequencer: a reference model expands each accepted op into its expected uop list;
// directed scenarios add cycle-exact literal expectations.
module tb_uop_sequencer;
  import uop_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n, flush, id_valid, id_ready, ex_valid, ex_ready, ex_last, ex_fault;
  logic [6:0]  id_reg_d, id_reg_s, id_reg_t, ex_reg_d, ex_reg_s, ex_reg_t;
  logic [31:0] id_imm, id_uop_word, ex_uop, ex_imm;
  logic [1:0]  id_step_pc, ex_step_pc;
  logic [11:0] id_uop_pc;

  always #5 clk = ~clk;

  uop_sequencer #(.UPC_W(12), .MAX_LEN(16), .ROM_FILE("")) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_reg_d(id_reg_d), .id_reg_s(id_reg_s), .id_reg_t(id_reg_t),
    .id_imm(id_imm), .id_step_pc(id_step_pc), .id_uop_pc(id_uop_pc), .id_uop_word(id_uop_word),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_uop(ex_uop),
    .ex_reg_d(ex_reg_d), .ex_reg_s(ex_reg_s), .ex_reg_t(ex_reg_t),
    .ex_imm(ex_imm), .ex_step_pc(ex_step_pc), .ex_last(ex_last), .ex_fault(ex_fault)
  );

  typedef struct packed {
    logic [31:0] uop;
    logic [31:0] imm;
    logic [6:0]  rd, rs, rt;
    logic [1:0]  step;
    logic        last;
    logic        fault;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rom_img [0:4095];
  logic [31:0] seq3 [0:2] = '{32'h10000001, 32'h11000002, 32'h12800003};
  exp_t        exp_q[$];
  logic [31:0] got_uop[$];
  logic [31:0] got_imm[$];
  logic [3:0]  got_flg[$];
  exp_t        prev;
  logic        prev_stall = 1'b0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Expand the op currently on id_* into the uops execute must see, from the word rules alone
  task automatic push_op();
    exp_t        e;
    logic [11:0] a;
    logic [31:0] w;
    if (id_uop_pc == 12'h000) begin
      e = {id_uop_word, id_imm, id_reg_d, id_reg_s, id_reg_t, id_step_pc, 1'b1, 1'b0};
      exp_q.push_back(e);
    end else begin
      a = id_uop_pc;
      for (int n = 1; n <= 16; n++) begin
        w       = rom_img[a];
        e.uop   = w;
        e.imm   = w[22] ? {{16{w[15]}}, w[15:0]} : id_imm;
        e.rd    = id_reg_d;
        e.rs    = id_reg_s;
        e.rt    = id_reg_t;
        e.fault = (a == 12'h000) || (n == 16 && !w[23]);
        e.last  = w[23] || e.fault;
        e.step  = (e.last && !e.fault) ? id_step_pc : 2'd0;
        exp_q.push_back(e);
        if (e.last) break;
        a = a + 12'd1;
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t cur, e;
    cur = {ex_uop, ex_imm, ex_reg_d, ex_reg_s, ex_reg_t, ex_step_pc, ex_last, ex_fault};
    if (!reset_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("hold", 96'({ex_valid, cur}), 96'({1'b1, prev}));
      if (ex_valid && ex_ready) begin
        got_uop.push_back(ex_uop);
        got_imm.push_back(ex_imm);
        got_flg.push_back({ex_step_pc, ex_last, ex_fault});
        if (exp_q.size() == 0) chk("extra_uop", 96'(ex_valid), 96'(0));
        else begin
          e = exp_q.pop_front();
          chk("uop", 96'(cur), 96'(e));
        end
      end
      prev       = cur;
      prev_stall = ex_valid && !ex_ready && !flush;
      if (flush) exp_q.delete();
      else if (id_valid && id_ready) push_op();
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic issue(input logic [11:0] pc, input logic [31:0] word, input logic [31:0] imm,
                       input logic [1:0] step);
    id_valid = 1'b1; id_uop_pc = pc; id_uop_word = word; id_imm = imm; id_step_pc = step;
    id_reg_d = 7'h11; id_reg_s = 7'h22; id_reg_t = 7'h33;
  endtask

  task automatic run_op(input logic [11:0] pc, input logic [31:0] imm, input logic [1:0] step,
                        input logic [3:0] pat, input int ncyc);
    got_uop.delete(); got_imm.delete(); got_flg.delete();
    cyc(); issue(pc, 32'h0, imm, step); ex_ready = 1'b1;
    smp(); chk("accept", 96'(id_ready), 96'(1));
    for (int k = 0; k < ncyc; k++) begin
      cyc(); id_valid = 1'b0; ex_ready = pat[k % 4];
    end
    smp();
    cyc(); ex_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) rom_img[i] = 32'h0;
    rom_img[12'h040] = {UOP_ALU, 24'h000001};
    rom_img[12'h041] = 32'h11000002;
    rom_img[12'h042] = 32'h12800003;
    rom_img[12'h060] = {UOP_BR, 8'h40, 16'hFFF0};
    rom_img[12'h061] = 32'h21801234;
    for (int i = 0; i < 16; i++) rom_img[12'h100 + i] = 32'h30000000 + i;
    rom_img[12'h110] = 32'h31800000;
    rom_img[12'hFFE] = 32'h40000000;
    rom_img[12'hFFF] = 32'h41000000;
    rom_img[12'h000] = 32'h42000000;
    for (int i = 0; i < 4096; i++) dut.u_rom.mem[i] = rom_img[i];

    reset_n = 1'b0; flush = 1'b0; ex_ready = 1'b0;
    issue(12'h000, 32'h0, 32'h0, 2'd0); id_valid = 1'b0;
    repeat (3) @(posedge clk);
    smp();
    chk("rst_id_ready", 96'(id_ready), 96'(0));
    chk("rst_outs", 96'({ex_valid, ex_uop, ex_imm, ex_reg_d, ex_reg_s, ex_reg_t, ex_step_pc, ex_last, ex_fault}), 96'(0));
    cyc(); reset_n = 1'b1;
    smp(); chk("ready_after_rst", 96'(id_ready), 96'(1));

    // direct op, latency 1
    cyc(); issue(12'h000, {UOP_LD, 24'h0}, 32'h12345678, 2'd1); ex_ready = 1'b1;
    smp(); chk("direct_accept", 96'(id_ready), 96'(1));
    cyc(); id_valid = 1'b0;
    smp();
    chk("direct_out", 96'({ex_valid, ex_uop, ex_last, ex_step_pc, ex_fault}), 96'({1'b1, 32'h0C000000, 1'b1, 2'd1, 1'b0}));
    chk("direct_imm", 96'(ex_imm), 96'(32'h12345678));

    // 3-uop sequence, cycle exact
    cyc(); issue(12'h040, 32'h0, 32'hAAAA0000, 2'd2);
    smp(); chk("seq3_accept", 96'(id_ready), 96'(1));
    for (int k = 1; k <= 5; k++) begin
      cyc(); id_valid = 1'b0;
      smp();
      chk("seq3_id_ready", 96'(id_ready), 96'(k == 5));
      if (k == 1 || k == 5) chk("seq3_gap", 96'(ex_valid), 96'(0));
      else chk("seq3_uop", 96'({ex_valid, ex_uop, ex_step_pc, ex_last}),
               96'({1'b1, seq3[k-2], (k == 4) ? 2'd2 : 2'd0, k == 4}));
    end

    // backpressure 1,0,0,1
    run_op(12'h040, 32'hAAAA0000, 2'd2, 4'b1001, 12);
    chk("bp_count", 96'(got_uop.size()), 96'(3));
    chk("bp_order", {got_uop[0], got_uop[1], got_uop[2]}, {32'h10000001, 32'h11000002, 32'h12800003});

    // SEL_IMM
    run_op(12'h060, 32'h55AA55AA, 2'd3, 4'b1111, 6);
    chk("selimm_imm", 96'({got_imm[0], got_imm[1]}), 96'({32'hFFFFFFF0, 32'h55AA55AA}));
    chk("selimm_last", 96'(got_flg[1]), 96'(4'b1110));

    // watchdog
    run_op(12'h100, 32'h0, 2'd1, 4'b1111, 20);
    chk("wdog_count", 96'(got_uop.size()), 96'(16));
    chk("wdog_15", 96'({got_uop[14], got_flg[14]}), 96'({32'h3000000E, 4'b0000}));
    chk("wdog_16", 96'({got_uop[15], got_flg[15]}), 96'({32'h3000000F, 4'b0011}));

    // wrap to address 0
    run_op(12'hFFE, 32'h0, 2'd2, 4'b1111, 8);
    chk("wrap_count", 96'(got_uop.size()), 96'(3));
    chk("wrap_pre", 96'(got_flg[1]), 96'(4'b0000));
    chk("wrap_fault", 96'({got_uop[2], got_flg[2]}), 96'({32'h42000000, 4'b0011}));

    // flush mid-sequence
    cyc(); issue(12'h100, 32'h0, 32'h0, 2'd1); ex_ready = 1'b0;
    smp(); chk("fl_accept", 96'(id_ready), 96'(1));
    cyc(); id_valid = 1'b0;
    cyc();
    smp(); chk("fl_stalled", 96'(ex_valid), 96'(1));
    cyc(); flush = 1'b1;
    smp(); chk("fl_id_ready", 96'(id_ready), 96'(0));
    cyc(); flush = 1'b0;
    smp(); chk("fl_after", 96'({ex_valid, id_ready}), 96'(2'b01));
    ex_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(); smp(); chk("fl_quiet", 96'(ex_valid), 96'(0));
    end

    // flush coincident with an accept attempt
    cyc(); issue(12'h000, {UOP_ST, 24'h0}, 32'h0, 2'd1); flush = 1'b1;
    smp(); chk("fl_acc_ready", 96'(id_ready), 96'(0));
    cyc(); flush = 1'b0; id_valid = 1'b0;
    smp(); chk("fl_no_accept", 96'(ex_valid), 96'(0));

    // reset mid-sequence
    cyc(); issue(12'h100, 32'h0, 32'h0, 2'd1); ex_ready = 1'b1;
    cyc(); id_valid = 1'b0;
    cyc(); cyc();
    smp(); chk("rst_mid_busy", 96'(ex_valid), 96'(1));
    cyc(); reset_n = 1'b0;
    smp(); chk("rst_mid_ready", 96'(id_ready), 96'(0));
    cyc();
    smp();
    chk("rst_mid_outs", 96'({ex_valid, ex_uop, ex_imm, ex_reg_d, ex_reg_s, ex_reg_t, ex_step_pc, ex_last, ex_fault}), 96'(0));
    cyc(); reset_n = 1'b1;
    smp(); chk("rst_mid_after", 96'({ex_valid, id_ready}), 96'(2'b01));
    cyc();
    smp(); chk("rst_mid_quiet", 96'(ex_valid), 96'(0));

    // recovery with a direct op
    cyc(); issue(12'h000, 32'h0C00BEEF, 32'h0BADF00D, 2'd3);
    cyc(); id_valid = 1'b0;
    smp(); chk("recover", 96'({ex_valid, ex_uop, ex_last}), 96'({1'b1, 32'h0C00BEEF, 1'b1}));
    repeat (3) cyc();
    smp(); chk("drain", 96'(exp_q.size()), 96'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
